aer_out_core_arbiter: RTL and testbench

// - Shares one AER output link among all cores of the LRF core array.
// - Round-robin arbitrates the cores' 4-phase AEROUT handshakes into a small event FIFO.
// - Drains the FIFO onto a single 4-phase AER output; the address carries the source core index.
// - Sits between the core array's AEROUT ports and the next layer or the host.

---
 rtl/aer_out_core_arbiter.sv | 152 +++++++++++++++
 tb/tb_aer_out_core_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_out_core_arbiter.sv
// aer_out_core_arbiter: merges the per-core 4-phase AEROUT handshakes of the
// core array into one 4-phase AER output through a small event FIFO.
// Output address is {core index, core address}.
// Optional macro AER_ARB_FIXED_PRIO_EN: when defined, the lowest requesting
// core index always wins; by default arbitration is round-robin.
module aer_out_core_arbiter #(
  parameter int CORE_NUM       = 256,
  parameter int CORE_AER_WIDTH = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [CORE_NUM-1:0]                          CORE_AEROUT_REQ,
  input  logic [CORE_NUM*CORE_AER_WIDTH-1:0]           CORE_AEROUT_ADDR,
  output logic [CORE_NUM-1:0]                          CORE_AEROUT_ACK,
  output logic                                         AEROUT_REQ,
  output logic [$clog2(CORE_NUM)+CORE_AER_WIDTH-1:0]   AEROUT_ADDR,
  input  logic                                         AEROUT_ACK,
  output logic [$clog2(FIFO_DEPTH):0]                  FIFO_LEVEL
);
  localparam int CORE_IDX_WIDTH = $clog2(CORE_NUM);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int EVT_W          = CORE_IDX_WIDTH + CORE_AER_WIDTH;

  typedef enum logic {IN_IDLE, IN_ACK} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT} out_state_t;

  in_state_t                 in_state_reg, in_state_next;
  out_state_t                out_state_reg, out_state_next;
  logic [CORE_IDX_WIDTH-1:0] gnt_reg, gnt_next, win_idx;
  logic [EVT_W-1:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]            level_reg;
  logic [EVT_W-1:0]          aer_addr_reg;
  logic                      any_req, fifo_full, fifo_empty, push, pop, load_head;

  assign any_req    = |CORE_AEROUT_REQ;
  assign fifo_full  = (level_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (level_reg == '0);
  assign pop        = (out_state_reg == OUT_REQ) && AEROUT_ACK;
  // A pop on the same edge frees the slot, so a push at full is still safe.
  assign push       = (in_state_reg == IN_IDLE) && any_req && (!fifo_full || pop);
  assign load_head  = (out_state_reg == OUT_IDLE) && !fifo_empty;

`ifdef AER_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest requesting core index wins.
  always_comb begin
    win_idx = '0;
    for (int i = CORE_NUM - 1; i >= 0; i--)
      if (CORE_AEROUT_REQ[i]) win_idx = CORE_IDX_WIDTH'(i);
  end
`else
  logic [CORE_IDX_WIDTH-1:0] ptr_reg, ptr_next, first_all, first_masked;
  logic [CORE_NUM-1:0]       ptr_mask;
  logic                      any_masked;

  for (genvar gi = 0; gi < CORE_NUM; gi++) begin : g_mask
    assign ptr_mask[gi] = (CORE_IDX_WIDTH'(gi) >= ptr_reg);
  end

  // Round-robin: first requester at or above ptr, otherwise wrap to the lowest.
  always_comb begin
    first_all    = '0;
    first_masked = '0;
    any_masked   = 1'b0;
    for (int i = CORE_NUM - 1; i >= 0; i--) begin
      if (CORE_AEROUT_REQ[i]) first_all = CORE_IDX_WIDTH'(i);
      if (CORE_AEROUT_REQ[i] && ptr_mask[i]) begin
        first_masked = CORE_IDX_WIDTH'(i);
        any_masked   = 1'b1;
      end
    end
    win_idx = any_masked ? first_masked : first_all;
  end

  // Pointer moves past the served core once its handshake completes.
  always_comb begin
    ptr_next = ptr_reg;
    if (in_state_reg == IN_ACK && !CORE_AEROUT_REQ[gnt_reg])
      ptr_next = (gnt_reg == CORE_IDX_WIDTH'(CORE_NUM - 1)) ? '0
                                                            : gnt_reg + CORE_IDX_WIDTH'(1);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_reg <= '0;
    else      ptr_reg <= ptr_next;
  end
`endif

  // Input handshake FSM: grant, hold ACK until the core drops REQ.
  always_comb begin
    in_state_next = in_state_reg;
    gnt_next      = gnt_reg;
    case (in_state_reg)
      IN_IDLE: if (push) begin
        gnt_next      = win_idx;
        in_state_next = IN_ACK;
      end
      IN_ACK: if (!CORE_AEROUT_REQ[gnt_reg]) in_state_next = IN_IDLE;
      default: in_state_next = IN_IDLE;
    endcase
  end

  // Output handshake FSM: present head, pop on ACK, wait for ACK release.
  always_comb begin
    out_state_next = out_state_reg;
    case (out_state_reg)
      OUT_IDLE: if (!fifo_empty) out_state_next = OUT_REQ;
      OUT_REQ:  if (AEROUT_ACK)  out_state_next = OUT_WAIT;
      OUT_WAIT: if (!AEROUT_ACK) out_state_next = OUT_IDLE;
      default:  out_state_next = OUT_IDLE;
    endcase
  end

  // State, FIFO pointers/level and output address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state_reg  <= IN_IDLE;
      out_state_reg <= OUT_IDLE;
      gnt_reg       <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      aer_addr_reg  <= '0;
    end else begin
      in_state_reg  <= in_state_next;
      out_state_reg <= out_state_next;
      gnt_reg       <= gnt_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      level_reg <= level_reg + (PTR_W+1)'(1);
      else if (pop && !push) level_reg <= level_reg - (PTR_W+1)'(1);
      if (load_head) aer_addr_reg <= fifo_mem[rd_ptr_reg];
    end
  end

  // Event storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= {win_idx, CORE_AEROUT_ADDR[win_idx*CORE_AER_WIDTH +: CORE_AER_WIDTH]};
  end

  for (genvar gi = 0; gi < CORE_NUM; gi++) begin : g_ack
    assign CORE_AEROUT_ACK[gi] = (in_state_reg == IN_ACK) && (gnt_reg == CORE_IDX_WIDTH'(gi));
  end

  assign AEROUT_REQ  = (out_state_reg == OUT_REQ);
  assign AEROUT_ADDR = aer_addr_reg;
  assign FIFO_LEVEL  = level_reg;

endmodule

// File: tb/tb_aer_out_core_arbiter.sv
// Testbench for aer_out_core_arbiter: the bench plays every core and the
// downstream receiver, and checks grants/outputs against a queue-based model.
module tb_aer_out_core_arbiter;
  localparam int N  = 256;
  localparam int AW = 4;
  localparam int D  = 4;
  localparam int IW = $clog2(N);
  localparam int OW = IW + AW;
  localparam int LW = $clog2(D) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    core_req = '0;
  logic [N*AW-1:0] core_addr = '0;
  logic [N-1:0]    core_ack;
  logic            aer_req;
  logic [OW-1:0]   aer_addr;
  logic            aer_ack = 1'b0;
  logic [LW-1:0]   fifo_level;

  aer_out_core_arbiter #(.CORE_NUM(N), .CORE_AER_WIDTH(AW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .CORE_AEROUT_REQ(core_req), .CORE_AEROUT_ADDR(core_addr), .CORE_AEROUT_ACK(core_ack),
    .AEROUT_REQ(aer_req), .AEROUT_ADDR(aer_addr), .AEROUT_ACK(aer_ack),
    .FIFO_LEVEL(fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int pend [N];
  int model_ptr = 0, model_level = 0;
  logic [OW-1:0] exp_q [$];
  int            grant_log [$];
  logic [OW-1:0] out_log [$];
  logic [N-1:0]  prev_ack = '0;
  logic          prev_aer = 1'b0;
  int req_prob = 100, ds_delay_max = 0, ds_cnt = 0, ds_delay_cur = 0;
  bit ds_block = 1'b0;
  int force_addr = -1, hold_core = -1, full_swap_cnt = 0, out_rises = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rule applied to the request vector the DUT sampled.
  function automatic int model_grant(input logic [N-1:0] r);
`ifdef AER_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int i = 0; i < N; i++) begin
      int k = (model_ptr + i) % N;
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  function automatic bit busy();
    int s = 0;
    for (int c = 0; c < N; c++) s += pend[c];
    return (s != 0) || (exp_q.size() != 0) || (core_req != '0) || (core_ack != '0) || aer_req || aer_ack;
  endfunction

  task automatic clear_model();
    model_ptr = 0; model_level = 0;
    exp_q.delete(); grant_log.delete(); out_log.delete();
    prev_ack = '0; prev_aer = 1'b0; ds_cnt = 0; ds_delay_cur = 0;
    full_swap_cnt = 0; out_rises = 0;
  endtask

  // One clock: observe at negedge, update the model, then drive cores/receiver.
  task automatic step();
    logic [N-1:0] ack_v;
    bit pop_now;
    int g, lvl_before;
    @(negedge clk);
    ack_v = core_ack;
    pop_now = 1'b0;
    lvl_before = model_level;
    check("ack_onehot", 64'($countones(ack_v) <= 1), 64'd1);
    if (aer_req && !prev_aer) begin
      out_rises++;
      check("out_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("out_addr", 64'(aer_addr), 64'(exp_q[0]));
      out_log.push_back(aer_addr);
    end else if (aer_req && exp_q.size() > 0) begin
      check("out_hold", 64'(aer_addr), 64'(exp_q[0]));
    end
    if (!aer_req && prev_aer) begin
      pop_now = 1'b1;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      model_level--;
    end
    for (int c = 0; c < N; c++) begin
      if (ack_v[c] && !prev_ack[c]) begin
        g = model_grant(core_req);
        check("grant_idx", 64'(c), 64'(g));
        check("grant_room", 64'(lvl_before < D || pop_now), 64'd1);
        if (pop_now && lvl_before == D) full_swap_cnt++;
        exp_q.push_back({IW'(c), core_addr[c*AW +: AW]});
        grant_log.push_back(c);
`ifndef AER_ARB_FIXED_PRIO_EN
        model_ptr = (c + 1) % N;
`endif
        model_level++;
        pend[c]--;
        if (c != hold_core) core_req[c] = 1'b0;
      end
    end
    check("fifo_level", 64'(fifo_level), 64'(model_level));
    for (int c = 0; c < N; c++) begin
      if (!core_req[c] && !ack_v[c] && pend[c] > 0 && int'($urandom_range(99)) < req_prob) begin
        core_req[c] = 1'b1;
        core_addr[c*AW +: AW] = (force_addr >= 0) ? AW'(force_addr) : AW'($urandom);
      end
    end
    if (aer_req && !aer_ack && !ds_block) begin
      if (ds_cnt >= ds_delay_cur) begin
        aer_ack = 1'b1;
        ds_cnt = 0;
        ds_delay_cur = int'($urandom_range(ds_delay_max));
      end else ds_cnt++;
    end else if (!aer_req && aer_ack) aer_ack = 1'b0;
    prev_ack = ack_v;
    prev_aer = aer_req;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin step(); n++; end
    check("drain_timeout", 64'(busy()), 64'd0);
    repeat (2) step();
  endtask

  // Asynchronous reset pulse with reset-state checks while rst is low.
  task automatic do_reset();
    core_req = '0; aer_ack = 1'b0; hold_core = -1; ds_block = 1'b0;
    for (int c = 0; c < N; c++) pend[c] = 0;
    rst = 1'b1; #1; rst = 1'b0; #1;
    check("rst_ack", 64'($countones(core_ack)), 64'd0);
    check("rst_aer_req", 64'(aer_req), 64'd0);
    check("rst_aer_addr", 64'(aer_addr), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    clear_model();
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic check_grants(input string tag, input int e [$]);
    check({tag, "_count"}, 64'(grant_log.size()), 64'(e.size()));
    for (int i = 0; i < e.size(); i++)
      check(tag, 64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(e[i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e [$];
    int sum;
    bit seen;

    // 1: single event from core 5, receiver answers one cycle after REQ.
    do_reset();
    force_addr = 10; ds_delay_max = 0; req_prob = 100;
    pend[5] = 1;
    drain(200);
    e = {5};
    check_grants("t1_grant", e);
    check("t1_out_count", 64'(out_log.size()), 64'd1);
    check("t1_out_addr", 64'((out_log.size() > 0) ? out_log[0] : '0), 64'({8'd5, 4'hA}));
    check("t1_req_pulses", 64'(out_rises), 64'd1);
    force_addr = -1;

    // 2: cores 3, 7, 200 with repeat requests; round-robin wrap.
    do_reset();
    pend[3] = 2; pend[7] = 2; pend[200] = 2;
    drain(500);
`ifdef AER_ARB_FIXED_PRIO_EN
    e = {3, 3, 7, 7, 200, 200};
`else
    e = {3, 7, 200, 3, 7, 200};
`endif
    check_grants("t2_order", e);

    // 3+4: receiver stalled, six requesters; FIFO fills, then drains in order.
    do_reset();
    ds_block = 1'b1;
    for (int k = 1; k <= 6; k++) pend[k*10] = 1;
    repeat (40) step();
    check("t3_level_full", 64'(fifo_level), 64'(D));
    check("t3_acks", 64'(grant_log.size()), 64'd4);
    check("t3_pending", 64'($countones(core_req)), 64'd2);
    ds_block = 1'b0;
    drain(500);
    check("t3_out_count", 64'(out_log.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      check("t3_out_order", 64'((k < out_log.size()) ? int'(out_log[k][OW-1:AW]) : -1), 64'((k + 1) * 10));
    check("t4_full_swap", 64'(full_swap_cnt > 0), 64'd1);

    // 5: reset while core 9 is acknowledged and the output request is up.
    do_reset();
    ds_block = 1'b1; hold_core = 9; pend[9] = 2;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      seen = core_ack[9] && aer_req;
    end
    check("t5_pre_state", 64'({core_ack[9], aer_req}), 64'd3);
    #2; rst = 1'b0; #1;
    check("t5_rst_ack", 64'($countones(core_ack)), 64'd0);
    check("t5_rst_aer_req", 64'(aer_req), 64'd0);
    check("t5_rst_level", 64'(fifo_level), 64'd0);
    clear_model();
    hold_core = -1; ds_block = 1'b0; aer_ack = 1'b0; pend[9] = 1;
    @(negedge clk); rst = 1'b1;
    drain(200);
    e = {9};
    check_grants("t5_reserve", e);
    check("t5_out_count", 64'(out_log.size()), 64'd1);

    // 6: cores 2 and 1 requesting continuously.
    do_reset();
    pend[1] = 3; pend[2] = 3;
    drain(500);
`ifdef AER_ARB_FIXED_PRIO_EN
    e = {1, 1, 1, 2, 2, 2};
`else
    e = {1, 2, 1, 2, 1, 2};
`endif
    check_grants("t6_order", e);

    // Random traffic with back-pressure, including the index wrap cores.
    do_reset();
    req_prob = 30; ds_delay_max = 6;
    pend[0] = 2; pend[255] = 2; pend[254] = 1; pend[1] = 1;
    for (int k = 0; k < 16; k++) pend[$urandom_range(N - 1)] += int'($urandom_range(1, 3));
    sum = 0;
    for (int c = 0; c < N; c++) sum += pend[c];
    drain(8000);
    check("rand_out_count", 64'(out_log.size()), 64'(sum));
    check("rand_grant_count", 64'(grant_log.size()), 64'(sum));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
